seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner: shadow-registered digit codes, prescaled digit
// rotation, one blank anode cycle per slot, leading-zero suppression, pin polarity.
`timescale 1ns/1ps
module seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int HEX_MODE       = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  slot_tick
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
    localparam logic HEX_EN  = (HEX_MODE != 0);

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_val;
    logic [DIGITS-1:0]     r_dp;
    logic                  r_blz;

    logic                  w_tick;
    logic [3:0]            w_nib;
    logic                  w_dp;
    logic                  w_lz;
    logic                  w_zero_above;
    logic [6:0]            w_seg;
    logic [DIGITS-1:0]     w_an_onehot;

    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:  pat = 7'b1111110;
            4'd1:  pat = 7'b0110000;
            4'd2:  pat = 7'b1101101;
            4'd3:  pat = 7'b1111001;
            4'd4:  pat = 7'b0110011;
            4'd5:  pat = 7'b1011011;
            4'd6:  pat = 7'b1011111;
            4'd7:  pat = 7'b1110000;
            4'd8:  pat = 7'b1111111;
            4'd9:  pat = 7'b1111011;
            4'd10: pat = HEX_EN ? 7'b1110111 : 7'b0000000;
            4'd11: pat = HEX_EN ? 7'b0011111 : 7'b0000000;
            4'd12: pat = HEX_EN ? 7'b1001110 : 7'b0000000;
            4'd13: pat = HEX_EN ? 7'b0111101 : 7'b0000000;
            4'd14: pat = HEX_EN ? 7'b1001111 : 7'b0000000;
            default: pat = HEX_EN ? 7'b1000111 : 7'b0000000;
        endcase
        return pat;
    endfunction

    assign w_tick    = (r_cnt == CNT_LAST);
    assign slot_tick = w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= '0;
            r_dp  <= '0;
            r_blz <= 1'b0;
        end else if (load) begin
            r_val <= value;
            r_dp  <= dp_in;
            r_blz <= blank_lz;
        end
    end

    // Walk from the top digit down so w_zero_above covers digits DIGITS-1..i.
    always_comb begin
        w_nib        = 4'd0;
        w_dp         = 1'b0;
        w_lz         = 1'b0;
        w_zero_above = 1'b1;
        w_an_onehot  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_val[4*i +: 4] == 4'd0);
            if (IW'(i) == r_idx) begin
                w_nib          = r_val[4*i +: 4];
                w_dp           = r_dp[i];
                w_lz           = r_blz && (i != 0) && w_zero_above;
                w_an_onehot[i] = 1'b1;
            end
        end
    end

    assign w_seg = w_lz ? 7'b0000000 : f_decode(w_nib);

    // The anodes go dark for the cycle after each tick so the old pattern never ghosts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= {7{SEG_INV}};
            dp  <= SEG_INV;
            an  <= {DIGITS{AN_INV}};
        end else begin
            seg <= w_seg ^ {7{SEG_INV}};
            dp  <= w_dp ^ SEG_INV;
            an  <= (w_tick ? '0 : w_an_onehot) ^ {DIGITS{AN_INV}};
        end
    end
endmodule
